// File: rtl/fpaddsub_prealign_stage.sv
// Two-stage binary32 add/sub front end: unpack, magnitude ordering, then alignment of the smaller mantissa with G/R/S.
// Subnormal operands are kept when FPADDSUB_DENORM_EN is defined; otherwise they are flushed to signed zero.
module fpaddsub_prealign_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        CtrlIn,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        Sa,
  output logic        Sb,
  output logic        Ctrl,
  output logic        MaxAB,
  output logic [4:0]  InputExc,
  output logic [7:0]  ExpMax,
  output logic [23:0] MaxM,
  output logic [26:0] MinM
);

  logic        vld_p1, vld_p2, adv2;
  logic [7:0]  expA, expB, effExpA, effExpB;
  logic [22:0] fracA, fracB;
  logic [23:0] mantA, mantB;
  logic [30:0] magA, magB;
  logic        bIsMax, infA, infB, nanA, nanB;
  logic [4:0]  excC;

  logic        sa_p1, sb_p1, ctrl_p1, maxAB_p1;
  logic [4:0]  exc_p1;
  logic [7:0]  expMax_p1, expDiff_p1;
  logic [23:0] maxM_p1, minM_p1;

  // Right shift of {m, G, R, S} by d; everything shifted past S is folded into S.
  function automatic logic [26:0] alignMin(input logic [23:0] m, input logic [7:0] d);
    logic [26:0] v, shifted, mask;
    v       = {m, 3'b000};
    shifted = '0;
    mask    = '0;
    if (d >= 8'd27) begin
      alignMin = {26'd0, |m};
    end else begin
      shifted  = v >> d;
      mask     = (27'd1 << d) - 27'd1;
      alignMin = {shifted[26:1], shifted[0] | (|(v & mask))};
    end
  endfunction

  assign adv2      = ~vld_p2 | out_ready;
  assign in_ready  = ~vld_p1 | adv2;
  assign out_valid = vld_p2;

  assign expA = A[30:23];
  assign expB = B[30:23];

`ifdef FPADDSUB_DENORM_EN
  assign fracA = A[22:0];
  assign fracB = B[22:0];
`else
  assign fracA = (expA == 8'd0) ? 23'd0 : A[22:0];
  assign fracB = (expB == 8'd0) ? 23'd0 : B[22:0];
`endif

  assign mantA   = {expA != 8'd0, fracA};
  assign mantB   = {expB != 8'd0, fracB};
  assign effExpA = (expA == 8'd0) ? 8'd1 : expA;
  assign effExpB = (expB == 8'd0) ? 8'd1 : expB;
  assign magA    = {expA, fracA};
  assign magB    = {expB, fracB};
  assign bIsMax  = magB > magA;

  // Exception classification looks at the raw fields, independent of flushing.
  assign infA = (expA == 8'hFF) && (A[22:0] == 23'd0);
  assign nanA = (expA == 8'hFF) && (A[22:0] != 23'd0);
  assign infB = (expB == 8'hFF) && (B[22:0] == 23'd0);
  assign nanB = (expB == 8'hFF) && (B[22:0] != 23'd0);
  assign excC = {nanB | (infA & infB & (A[31] ^ B[31] ^ CtrlIn)),
                 nanA, infB, infA, infA | infB | nanA | nanB};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (in_ready) vld_p1 <= in_valid;
      if (adv2)     vld_p2 <= vld_p1;
    end
  end

  // Stage 1: unpack and order operands by magnitude
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      sa_p1    <= A[31];
      sb_p1    <= B[31];
      ctrl_p1  <= CtrlIn;
      maxAB_p1 <= bIsMax;
      exc_p1   <= excC;
      if (bIsMax) begin
        expMax_p1  <= expB;
        maxM_p1    <= mantB;
        minM_p1    <= mantA;
        expDiff_p1 <= effExpB - effExpA;
      end else begin
        expMax_p1  <= expA;
        maxM_p1    <= mantA;
        minM_p1    <= mantB;
        expDiff_p1 <= effExpA - effExpB;
      end
    end
  end

  // Stage 2: align the smaller mantissa
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Sa       <= 1'b0;
      Sb       <= 1'b0;
      Ctrl     <= 1'b0;
      MaxAB    <= 1'b0;
      InputExc <= 5'd0;
      ExpMax   <= 8'd0;
      MaxM     <= 24'd0;
      MinM     <= 27'd0;
    end else if (vld_p1 && adv2) begin
      Sa       <= sa_p1;
      Sb       <= sb_p1;
      Ctrl     <= ctrl_p1;
      MaxAB    <= maxAB_p1;
      InputExc <= exc_p1;
      ExpMax   <= expMax_p1;
      MaxM     <= maxM_p1;
      MinM     <= alignMin(minM_p1, expDiff_p1);
    end
  end

endmodule

// File: tb/tb_fpaddsub_prealign_stage.sv
// Scoreboard bench for fpaddsub_prealign_stage: directed vectors, stall, random traffic and mid-flight reset.
module tb_fpaddsub_prealign_stage;

  typedef logic [67:0] vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, CtrlIn, out_valid, out_ready;
  logic [31:0] A, B;
  logic        Sa, Sb, Ctrl, MaxAB;
  logic [4:0]  InputExc;
  logic [7:0]  ExpMax;
  logic [23:0] MaxM;
  logic [26:0] MinM;

  vec_t expQ[$];
  int   checks = 0;
  int   errors = 0;
  int   nOut = 0;
  bit   stallPrev = 0;
  vec_t stallVec;
  bit   randReady = 0;

  always #5 clk = ~clk;

  fpaddsub_prealign_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .CtrlIn(CtrlIn), .out_valid(out_valid), .out_ready(out_ready),
    .Sa(Sa), .Sb(Sb), .Ctrl(Ctrl), .MaxAB(MaxAB), .InputExc(InputExc),
    .ExpMax(ExpMax), .MaxM(MaxM), .MinM(MinM)
  );

  function automatic vec_t curVec();
    return {Sa, Sb, Ctrl, MaxAB, InputExc, ExpMax, MaxM, MinM};
  endfunction

  // Reference: IEEE field rules evaluated with integer arithmetic.
  function automatic vec_t model(input logic [31:0] a, input logic [31:0] b, input logic c);
    int ea, eb, fa, fb, ma, mb, effA, effB, d, maxE, maxMant, minMant;
    longint magA, magB, v, p, minA;
    bit bBig, infA, infB, nanA, nanB;
    logic [4:0] exc;
    ea = int'(a[30:23]); eb = int'(b[30:23]);
    fa = int'(a[22:0]);  fb = int'(b[22:0]);
    infA = (ea == 255) && (fa == 0); nanA = (ea == 255) && (fa != 0);
    infB = (eb == 255) && (fb == 0); nanB = (eb == 255) && (fb != 0);
`ifndef FPADDSUB_DENORM_EN
    if (ea == 0) fa = 0;
    if (eb == 0) fb = 0;
`endif
    magA = longint'(ea) * 8388608 + longint'(fa);
    magB = longint'(eb) * 8388608 + longint'(fb);
    bBig = magB > magA;
    ma = (ea != 0 ? 8388608 : 0) + fa;
    mb = (eb != 0 ? 8388608 : 0) + fb;
    effA = (ea == 0) ? 1 : ea;
    effB = (eb == 0) ? 1 : eb;
    if (bBig) begin maxE = eb; maxMant = mb; minMant = ma; d = effB - effA; end
    else      begin maxE = ea; maxMant = ma; minMant = mb; d = effA - effB; end
    if (d >= 27) minA = (minMant != 0) ? 1 : 0;
    else begin
      v = longint'(minMant) * 8;
      p = longint'(1) << d;
      minA = v / p;
      if (v % p != 0) minA = minA | 1;
    end
    exc[1] = infA; exc[2] = infB; exc[3] = nanA;
    exc[4] = nanB | (infA & infB & (a[31] ^ b[31] ^ c));
    exc[0] = infA | infB | nanA | nanB;
    return {a[31], b[31], c, bBig, exc, 8'(maxE), 24'(maxMant), 27'(minA)};
  endfunction

  function automatic logic [31:0] randOp(input logic [31:0] other);
    logic [31:0] r;
    int e;
    r = $urandom;
    e = int'(other[30:23]);
    case ($urandom_range(0, 7))
      0: ;
      1: begin r[30:23] = 8'd0; if ($urandom_range(0, 1) == 0) r[22:0] = 23'd0; end
      2: begin r[30:23] = 8'hFF; if ($urandom_range(0, 1) == 0) r[22:0] = 23'd0; end
      3: r[30:23] = other[30:23];
      4: begin e = e - $urandom_range(0, 35); r[30:23] = 8'((e < 0) ? 0 : e); end
      5: begin e = e + $urandom_range(0, 35); r[30:23] = 8'((e > 254) ? 254 : e); end
      6: r[30:0] = other[30:0];
      default: r[30:23] = 8'($urandom_range(100, 150));
    endcase
    return r;
  endfunction

  task automatic sendVec(input logic [31:0] a, input logic [31:0] b, input logic c, input vec_t e);
    int  n;
    bit  done;
    n = 0; done = 0;
    A = a; B = b; CtrlIn = c; in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin expQ.push_back(e); done = 1; end
      @(posedge clk); #1;
      n++;
      if (!done && n > 200) begin
        checks++; errors++;
        $display("FAIL send_timeout in_ready stuck at %0b, required 1 within 200 cycles", in_ready);
        done = 1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic sendModel(input logic [31:0] a, input logic [31:0] b, input logic c);
    sendVec(a, b, c, model(a, b, c));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL drain results_pending %0d, required 0", expQ.size());
    end
  endtask

  task automatic checkVal(input string name, input logic [68:0] got, input logic [68:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h required %h", name, got, want);
    end
  endtask

  // Monitor: pops the scoreboard on each transfer and checks hold during stalls.
  always @(negedge clk) begin
    vec_t cur, e;
    if (!rst_n) stallPrev = 0;
    else begin
      cur = curVec();
      if (stallPrev) begin
        checks++;
        if ({out_valid, cur} !== {1'b1, stallVec}) begin
          errors++;
          $display("FAIL stall_hold got %b/%h required 1/%h", out_valid, cur, stallVec);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output got %h required no output", cur);
        end else begin
          e = expQ.pop_front();
          nOut++;
          if (cur !== e) begin
            errors++;
            $display("FAIL result got %h required %h", cur, e);
          end
        end
      end
      stallPrev = out_valid && !out_ready;
      stallVec  = cur;
    end
  end

  always @(posedge clk) begin
    if (randReady) begin
      #1;
      if (randReady) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, w;
    logic [31:0] ra, rb;
    rst_n = 1'b0; in_valid = 1'b0; A = '0; B = '0; CtrlIn = 1'b0; out_ready = 1'b1;
    #2;
    checkVal("reset_outputs", {out_valid, curVec()}, 69'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkVal("reset_in_ready", {68'd0, in_ready}, 69'd1);
    @(posedge clk); #1;

    sendVec(32'h3F800000, 32'h3F800000, 1'b0,
            {4'b0000, 5'b00000, 8'h7F, 24'h800000, 27'h4000000});
    sendVec(32'h3F800000, 32'h30800000, 1'b0,
            {4'b0000, 5'b00000, 8'h7F, 24'h800000, 27'h0000001});
    sendVec(32'h40000000, 32'hC0400000, 1'b1,
            {4'b0111, 5'b00000, 8'h80, 24'hC00000, 27'h4000000});
    sendVec(32'h7F800000, 32'h7F800000, 1'b1,
            {4'b0010, 5'b10111, 8'hFF, 24'h800000, 27'h4000000});
    sendVec(32'h7FC00000, 32'h7F800000, 1'b1,
            {4'b0010, 5'b01101, 8'hFF, 24'hC00000, 27'h4000000});
`ifdef FPADDSUB_DENORM_EN
    sendVec(32'h00000001, 32'h00000000, 1'b0,
            {4'b0000, 5'b00000, 8'h00, 24'h000001, 27'h0000000});
`else
    sendVec(32'h00000001, 32'h00000000, 1'b0,
            {4'b0000, 5'b00000, 8'h00, 24'h000000, 27'h0000000});
`endif
    drain();

    // Stall: four back-to-back pairs, out_ready low for three cycles after the first result.
    n0 = nOut;
    fork
      begin
        sendModel(32'h3FC00000, 32'h3E000000, 1'b0);
        sendModel(32'hC1200000, 32'h41A00000, 1'b1);
        sendModel(32'h42F60000, 32'h3F000001, 1'b0);
        sendModel(32'h00400000, 32'h80200000, 1'b1);
      end
      begin
        w = 0;
        @(negedge clk);
        while (!out_valid && w < 50) begin @(negedge clk); w++; end
        @(posedge clk); #1 out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkVal("stall_in_ready", {68'd0, in_ready}, 69'd0);
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    drain();
    checkVal("stall_count", 69'(nOut - n0), 69'd4);

    // Random traffic with random backpressure.
    randReady = 1;
    for (int i = 0; i < 300; i++) begin
      ra = $urandom;
      if ($urandom_range(0, 3) == 0) ra = randOp(ra);
      rb = randOp(ra);
      if ($urandom_range(0, 1) == 0) sendModel(ra, rb, 1'($urandom_range(0, 1)));
      else sendModel(rb, ra, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 5) == 0) begin @(posedge clk); #1; end
    end
    randReady = 0;
    @(posedge clk); #1 out_ready = 1'b1;
    drain();

    // Reset with two results in flight.
    out_ready = 1'b0;
    sendModel(32'h40490FDB, 32'h3F800000, 1'b0);
    sendModel(32'hBF000000, 32'h3E800000, 1'b1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    checkVal("midreset_outputs", {out_valid, curVec()}, 69'd0);
    expQ.delete();
    n0 = nOut;
    @(posedge clk); #1 rst_n = 1'b1; out_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      checkVal("post_reset_out_valid", {68'd0, out_valid}, 69'd0);
    end
    checkVal("post_reset_count", 69'(nOut - n0), 69'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
